fios_operand_server: RTL and testbench
======================================

// Module: fios_operand_server
// PURPOSE
// - Memory-side counterpart of the FIOS multiplier controller: it serves the multiplier's operand requests and collects its result words.
// - Loads operands A, B, P word-serially from a host stream, then issues start to the multiplier.
// - Answers a_shift/b_fetch/p_fetch with the next operand words and captures RES words on RES_push.
// - After done, streams the s-word result back to the host.
// PARAMETERS
// - s      8  number of 17-bit words per operand (s >= 2)
// - PE_NB  8  number of PEs fed in parallel by a_o; 1 <= PE_NB <= s; PE_NB == s for EXPAND
// PORTS
// - clock_i         in   1         single clock, all logic on posedge
// - reset_i         in   1         asynchronous, active-high reset
// - ld_valid_i      in   1         host operand word valid
// - ld_ready_o      out  1         server accepts operand word
// - ld_data_i       in   17        operand word; order A[0..s-1], B[0..s-1], P[0..s-1], LSW first
// - start_o         out  1         one-cycle start pulse to multiplier
// - a_o             out  PE_NB*17  A window; slice j = A[base+j], 0 if base+j >= s
// - a_shift_i       in   1         advance A window by PE_NB words
// - b_o / p_o       out  17 each   B[b_ptr] / P[p_ptr]
// - b_fetch_i       in   1         advance b_ptr
// - p_fetch_i       in   1         advance p_ptr
// - res_push_i      in   1         capture res_i
// - res_i           in   17        multiplier result word
// - done_i          in   1         multiplication finished
// - out_valid_o     out  1         result word valid
// - out_ready_i     in   1         host accepts result word
// - out_data_o      out  17        result word, LSW first
// - out_last_o      out  1         marks word s-1
// - busy_o          out  1         high in any state except IDLE
// - err_o           out  1         sticky protocol error
// BEHAVIOUR
// - Reset (async, any state): state IDLE. All pointers, base and buffers' valid flags = 0.
//   Outputs start_o, out_valid_o, out_last_o, busy_o, err_o = 0; ld_ready_o = 1. a_o, b_o, p_o, out_data_o = 0.
// - FSM: IDLE -> LOAD -> RUN -> OUT -> IDLE.
// - IDLE: ld_ready_o = 1. The first accepted word (ld_valid_i & ld_ready_o) moves to LOAD, word index 1.
// - LOAD: one word is written per handshake at index w; A for w < s, B for w < 2s, P for w < 3s.
//   When word 3s-1 is accepted, the next cycle enters RUN with start_o = 1 for exactly that cycle.
//   On the same cycle, base, b_ptr, p_ptr and res_ptr are cleared.
// - RUN: ld_ready_o = 0. All pointer updates are registered, so a new word is visible the cycle after the request.
//   - a_shift_i: base += PE_NB. Once base >= s, every slice of a_o reads 0.
//   - b_fetch_i: b_ptr = (b_ptr == s-1) ? 0 : b_ptr+1 (wrap). p_fetch_i behaves the same on p_ptr.
//   - Simultaneous a_shift/b_fetch/p_fetch/res_push requests are all honoured in the same cycle.
//   - res_push_i: res_buf[res_ptr] <= res_i; res_ptr++. A push with res_ptr == s sets err_o and the word is dropped.
//   - done_i: go to OUT. If res_ptr != s when done_i arrives, set err_o; OUT still runs and unfilled words read 0.
//   - A res_push_i in the same cycle as done_i is captured before the transition.
// - OUT: out_valid_o = 1 and out_data_o = res_buf[k]; k advances on out_valid_o & out_ready_i.
//   out_last_o = (k == s-1). The handshake on the last word returns the FSM to IDLE.
// - err_o clears only on reset or on the next accepted IDLE load word.
// - Protocol inputs outside their legal state are ignored and set err_o:
//   a_shift_i, b_fetch_i, p_fetch_i, res_push_i, done_i outside RUN; ld_valid_i is not an error.
// - Latency: start_o follows the last load handshake by 1 cycle.
//   First out_valid_o follows done_i by 1 cycle; throughput is 1 word/cycle.
// CONFIGURATION
// - Macro FIOS_SERVER_PERF_CNT_EN.
// - Defined: adds output perf_cnt_o [31:0].
//   - Cleared on the start_o cycle; increments every RUN cycle; holds after done_i; saturates at 32'hFFFF_FFFF.
//   - Reset value 0.
// - Undefined: port and counter are absent; all other behaviour is identical.
// TESTING (s=4, PE_NB=2 unless stated)
// - Load A=1,2,3,4 B=5,6,7,8 P=9,A,B,C:
//   start_o pulses once 1 cycle after the 12th handshake; a_o={2,1}; b_o=5; p_o=9.
// - Pulse a_shift_i twice: a_o={4,3}, then {0,0}.
//   Pulse b_fetch_i 5 times: b_o=6,7,8,5,6 (wrap).
// - Push res 11,22,33,44, then done_i: out_data_o=11,22,33,44 with out_last_o on 44.
//   Hold out_ready_i=0 for 3 cycles: data stays 11 and valid stays high.
// - Error cases: a 5th res_push_i sets err_o and out_data_o still = 11,22,33,44.
//   done_i after 2 pushes sets err_o and the output reads 11,22,0,0.
// - Assert reset_i mid-RUN (after 1 push): busy_o=0, ld_ready_o=1 and err_o=0 immediately.
//   A full reload then works.
// - With FIOS_SERVER_PERF_CNT_EN and done_i 37 cycles after start_o: perf_cnt_o=37 and it holds through OUT.

Source files
------------

// File: rtl/fios_operand_server.sv
// Operand/result server for the FIOS multiplier: loads A/B/P from the host, serves operand windows, collects RES words.
// Optional cycle counter perf_cnt_o is enabled by defining FIOS_SERVER_PERF_CNT_EN.
module fios_operand_server #(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [16:0]           ld_data_i,
    output logic                  start_o,
    output logic [PE_NB*17-1:0]   a_o,
    input  logic                  a_shift_i,
    output logic [16:0]           b_o,
    output logic [16:0]           p_o,
    input  logic                  b_fetch_i,
    input  logic                  p_fetch_i,
    input  logic                  res_push_i,
    input  logic [16:0]           res_i,
    input  logic                  done_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [16:0]           out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  err_o
`ifdef FIOS_SERVER_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cnt_o
`endif
);
    localparam int WIDX_W = $clog2(3 * s);
    localparam int PTR_W  = $clog2(s);
    localparam int RCNT_W = $clog2(s + 1);
    localparam int BASE_W = $clog2(s + PE_NB) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    state_t              state_q;
    logic [WIDX_W-1:0]   w_q;
    logic [BASE_W-1:0]   base_q;
    logic [PTR_W-1:0]    b_ptr_q, p_ptr_q, k_q;
    logic [RCNT_W-1:0]   res_ptr_q, res_cnt_d;
    logic                start_q, err_q, err_d, opnd_vld_q;
    logic [s-1:0]        res_vld_q, res_vld_d;
    logic [16:0]         a_mem [s];
    logic [16:0]         b_mem [s];
    logic [16:0]         p_mem [s];
    logic [16:0]         res_mem [s];

    logic              ld_fire, last_word, res_fire, in_run, stray;
    logic [WIDX_W-1:0] widx;

    assign in_run    = (state_q == RUN);
    assign ld_fire   = ld_valid_i & ld_ready_o;
    assign widx      = (state_q == LOAD) ? w_q : '0;
    assign last_word = (state_q == LOAD) && (w_q == WIDX_W'(3 * s - 1));
    assign res_fire  = in_run & res_push_i & (res_ptr_q != RCNT_W'(s));
    assign stray     = ~in_run & (a_shift_i | b_fetch_i | p_fetch_i | res_push_i | done_i);
    assign res_cnt_d = res_ptr_q + {{(RCNT_W-1){1'b0}}, res_fire};

    // A push that lands with done_i still counts towards the completeness check.
    always_comb begin
        err_d = ((state_q == IDLE) && ld_fire) ? 1'b0 : err_q;
        if (stray || (in_run && res_push_i && !res_fire) ||
            (in_run && done_i && res_cnt_d != RCNT_W'(s)))
            err_d = 1'b1;
        res_vld_d = res_vld_q;
        if (ld_fire && last_word)
            res_vld_d = '0;
        else if (res_fire)
            res_vld_d = res_vld_q | ({{(s-1){1'b0}}, 1'b1} << res_ptr_q);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            w_q        <= '0;
            base_q     <= '0;
            b_ptr_q    <= '0;
            p_ptr_q    <= '0;
            res_ptr_q  <= '0;
            k_q        <= '0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            opnd_vld_q <= 1'b0;
            res_vld_q  <= '0;
        end else begin
            start_q   <= 1'b0;
            err_q     <= err_d;
            res_vld_q <= res_vld_d;
            case (state_q)
                IDLE: if (ld_fire) begin
                    state_q    <= LOAD;
                    w_q        <= WIDX_W'(1);
                    opnd_vld_q <= 1'b0;
                end
                LOAD: if (ld_fire) begin
                    if (last_word) begin
                        state_q    <= RUN;
                        start_q    <= 1'b1;
                        base_q     <= '0;
                        b_ptr_q    <= '0;
                        p_ptr_q    <= '0;
                        res_ptr_q  <= '0;
                        opnd_vld_q <= 1'b1;
                    end else begin
                        w_q <= w_q + WIDX_W'(1);
                    end
                end
                RUN: begin
                    // base stops once past the end; every slice already reads 0 there.
                    if (a_shift_i && base_q < BASE_W'(s))
                        base_q <= base_q + BASE_W'(PE_NB);
                    if (b_fetch_i)
                        b_ptr_q <= (b_ptr_q == PTR_W'(s - 1)) ? '0 : b_ptr_q + PTR_W'(1);
                    if (p_fetch_i)
                        p_ptr_q <= (p_ptr_q == PTR_W'(s - 1)) ? '0 : p_ptr_q + PTR_W'(1);
                    res_ptr_q <= res_cnt_d;
                    if (done_i) begin
                        state_q <= OUT;
                        k_q     <= '0;
                    end
                end
                OUT: if (out_ready_i) begin
                    if (k_q == PTR_W'(s - 1))
                        state_q <= IDLE;
                    else
                        k_q <= k_q + PTR_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        for (int i = 0; i < s; i++) begin
            if (ld_fire && widx == WIDX_W'(i))         a_mem[i]   <= ld_data_i;
            if (ld_fire && widx == WIDX_W'(s + i))     b_mem[i]   <= ld_data_i;
            if (ld_fire && widx == WIDX_W'(2 * s + i)) p_mem[i]   <= ld_data_i;
            if (res_fire && res_ptr_q == RCNT_W'(i))   res_mem[i] <= res_i;
        end
    end

    for (genvar gi = 0; gi < PE_NB; gi++) begin : g_a_win
        logic [BASE_W-1:0] a_idx;
        assign a_idx = base_q + BASE_W'(gi);
        assign a_o[gi*17 +: 17] = (opnd_vld_q && a_idx < BASE_W'(s)) ? a_mem[a_idx[PTR_W-1:0]] : 17'd0;
    end

    assign b_o         = opnd_vld_q ? b_mem[b_ptr_q] : 17'd0;
    assign p_o         = opnd_vld_q ? p_mem[p_ptr_q] : 17'd0;
    assign start_o     = start_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != IDLE);
    assign ld_ready_o  = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid_o = (state_q == OUT);
    assign out_last_o  = (state_q == OUT) && (k_q == PTR_W'(s - 1));
    assign out_data_o  = ((state_q == OUT) && res_vld_q[k_q]) ? res_mem[k_q] : 17'd0;

`ifdef FIOS_SERVER_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            perf_q <= '0;
        else if (ld_fire && last_word)
            perf_q <= '0;
        else if (in_run && !done_i && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end
    assign perf_cnt_o = perf_q;
`endif
endmodule

// File: tb/tb_fios_operand_server.sv
// Bench for fios_operand_server (s=4, PE_NB=2): behavioural model plus directed literal checks and random runs.
module tb_fios_operand_server;
    localparam int S  = 4;
    localparam int PE = 2;

    logic clk = 1'b0;
    logic rst;
    logic ld_valid_i, a_shift_i, b_fetch_i, p_fetch_i, res_push_i, done_i, out_ready_i;
    logic [16:0] ld_data_i, res_i;
    logic ld_ready_o, start_o, out_valid_o, out_last_o, busy_o, err_o;
    logic [PE*17-1:0] a_o;
    logic [16:0] b_o, p_o, out_data_o;
`ifdef FIOS_SERVER_PERF_CNT_EN
    logic [31:0] perf_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fios_operand_server #(.s(S), .PE_NB(PE)) dut (
        .clock_i(clk), .reset_i(rst),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
        .start_o(start_o), .a_o(a_o), .a_shift_i(a_shift_i),
        .b_o(b_o), .p_o(p_o), .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i),
        .res_push_i(res_push_i), .res_i(res_i), .done_i(done_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .err_o(err_o)
`ifdef FIOS_SERVER_PERF_CNT_EN
        , .perf_cnt_o(perf_cnt_o)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (phase 0 idle, 1 load, 2 run, 3 out) ----------------
    int          m_phase, m_w, m_base, m_b, m_p, m_rcnt, m_k;
    logic [16:0] m_a [S];
    logic [16:0] m_bv [S];
    logic [16:0] m_pv [S];
    logic [16:0] m_res [S];
    logic        m_start, m_err, m_loaded;
    longint      m_perf;

    logic m_stray, m_ovf, m_short;
    int   m_cnt_after;
    assign m_stray = (m_phase != 2) && (a_shift_i || b_fetch_i || p_fetch_i || res_push_i || done_i);
    assign m_ovf   = (m_phase == 2) && res_push_i && (m_rcnt >= S);
    assign m_cnt_after = m_rcnt + (((m_phase == 2) && res_push_i && (m_rcnt < S)) ? 1 : 0);
    assign m_short = (m_phase == 2) && done_i && (m_cnt_after != S);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_w <= 0; m_base <= 0; m_b <= 0; m_p <= 0; m_rcnt <= 0; m_k <= 0;
            m_start <= 1'b0; m_err <= 1'b0; m_loaded <= 1'b0; m_perf <= 0;
            for (int i = 0; i < S; i++) m_res[i] <= 17'd0;
        end else begin
            m_start <= 1'b0;
            m_err <= (((m_phase == 0) && ld_valid_i) ? 1'b0 : m_err) | m_stray | m_ovf | m_short;
            case (m_phase)
                0: if (ld_valid_i) begin
                    m_a[0] <= ld_data_i; m_w <= 1; m_phase <= 1;
                end
                1: if (ld_valid_i) begin
                    if (m_w < S) m_a[m_w] <= ld_data_i;
                    else if (m_w < 2 * S) m_bv[m_w - S] <= ld_data_i;
                    else m_pv[m_w - 2 * S] <= ld_data_i;
                    if (m_w == 3 * S - 1) begin
                        m_phase <= 2; m_start <= 1'b1; m_loaded <= 1'b1;
                        m_base <= 0; m_b <= 0; m_p <= 0; m_rcnt <= 0; m_perf <= 0;
                        for (int i = 0; i < S; i++) m_res[i] <= 17'd0;
                    end else begin
                        m_w <= m_w + 1;
                    end
                end
                2: begin
                    if (a_shift_i) m_base <= m_base + PE;
                    if (b_fetch_i) m_b <= (m_b + 1) % S;
                    if (p_fetch_i) m_p <= (m_p + 1) % S;
                    if (res_push_i && m_rcnt < S) m_res[m_rcnt] <= res_i;
                    m_rcnt <= m_cnt_after;
                    if (done_i) begin
                        m_phase <= 3; m_k <= 0;
                    end else if (m_perf < 64'hFFFF_FFFF) begin
                        m_perf <= m_perf + 1;
                    end
                end
                default: if (out_ready_i) begin
                    if (m_k == S - 1) m_phase <= 0;
                    else m_k <= m_k + 1;
                end
            endcase
        end
    end

    function automatic logic [PE*17-1:0] exp_a();
        logic [PE*17-1:0] v = '0;
        for (int j = 0; j < PE; j++)
            if (m_loaded && (m_base + j) < S) v[j*17 +: 17] = m_a[m_base + j];
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("busy", busy_o, m_phase != 0);
        chk("ld_ready", ld_ready_o, m_phase <= 1);
        chk("start", start_o, m_start);
        chk("err", err_o, m_err);
        chk("out_valid", out_valid_o, m_phase == 3);
        if (m_phase == 3) begin
            chk("out_data", out_data_o, m_res[m_k]);
            chk("out_last", out_last_o, m_k == S - 1);
        end
        if (m_phase == 2 || !m_loaded) begin
            chk("a_win", a_o, exp_a());
            chk("b_word", b_o, m_loaded ? m_bv[m_b] : 17'd0);
            chk("p_word", p_o, m_loaded ? m_pv[m_p] : 17'd0);
        end
`ifdef FIOS_SERVER_PERF_CNT_EN
        chk("perf", perf_cnt_o, m_perf);
`endif
    end

    // ---------------- stimulus ----------------
    logic [16:0] ops [3*S];
    logic [16:0] exp_out [S];
    int bl [5] = '{6, 7, 8, 5, 6};

    task automatic tick();
        @(negedge clk);
        ld_valid_i = 0; a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; res_push_i = 0; done_i = 0;
    endtask

    // Returns at the negedge where the start cycle is visible.
    task automatic load_ops(input bit gaps, input int stray_at);
        int i = 0;
        int c = 0;
        while (i < 3 * S && c < 1000) begin
            if (!gaps || ($urandom % 4) != 0) begin
                ld_valid_i = 1; ld_data_i = ops[i];
                if (i == stray_at) a_shift_i = 1;
                i++;
            end
            tick();
            c++;
        end
    endtask

    task automatic push(input logic [16:0] v);
        res_push_i = 1; res_i = v; tick();
    endtask

    task automatic drain(input int stall0);
        for (int i = 0; i < S; i++) begin
            for (int t = 0; t < ((i == 0) ? stall0 : 0); t++) begin
                out_ready_i = 0;
                chk("hold_valid", out_valid_o, 1);
                chk("hold_data", out_data_o, exp_out[i]);
                tick();
            end
            chk("drain_data", out_data_o, exp_out[i]);
            chk("drain_last", out_last_o, i == S - 1);
            out_ready_i = 1;
            tick();
        end
        out_ready_i = 0;
        chk("drain_idle", busy_o, 0);
    endtask

    task automatic run_phase(input int npush, input bit done_with_last);
        int pushed = 0;
        int c = 0;
        while (pushed < npush && c < 200) begin
            a_shift_i = ($urandom % 3) == 0;
            b_fetch_i = ($urandom % 2) == 0;
            p_fetch_i = ($urandom % 2) == 0;
            if ($urandom % 2) begin
                res_push_i = 1; res_i = 17'($urandom); pushed++;
                if (pushed == npush && done_with_last) done_i = 1;
            end
            tick();
            c++;
        end
        if (!done_with_last || npush == 0) begin
            done_i = 1; tick();
        end
    endtask

    task automatic rand_drain();
        int c = 0;
        while (m_phase == 3 && c < 200) begin
            out_ready_i = $urandom % 2;
            tick();
            c++;
        end
        out_ready_i = 0;
        chk("rand_drain_done", busy_o, 0);
    endtask

    initial begin
        ld_valid_i = 0; a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; res_push_i = 0;
        done_i = 0; out_ready_i = 0; ld_data_i = 0; res_i = 0;
        rst = 0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", ld_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_a", a_o, 0);
        chk("rst_out_data", out_data_o, 0);
        rst = 0;

        // Directed: A=1..4 B=5..8 P=9..C
        for (int i = 0; i < 3 * S; i++) ops[i] = 17'(i + 1);
        tick();
        load_ops(0, -1);
        chk("start_pulse", start_o, 1);
        chk("a_first", a_o, {17'd2, 17'd1});
        chk("b_first", b_o, 17'd5);
        chk("p_first", p_o, 17'd9);
        tick();
        chk("start_once", start_o, 0);
        a_shift_i = 1; tick(); chk("a_shift1", a_o, {17'd4, 17'd3});
        a_shift_i = 1; tick(); chk("a_shift2", a_o, 0);
        for (int i = 0; i < 5; i++) begin
            b_fetch_i = 1; tick(); chk("b_wrap", b_o, 17'(bl[i]));
        end
        for (int i = 0; i < S; i++) push(17'((i + 1) * 11));
        done_i = 1; tick();
        chk("no_err", err_o, 0);
        exp_out = '{17'd11, 17'd22, 17'd33, 17'd44};
        drain(3);

        // Stray request in IDLE sets err; next accepted load word clears it.
        b_fetch_i = 1; tick();
        chk("stray_err", err_o, 1);
        for (int i = 0; i < 3 * S; i++) ops[i] = 17'($urandom);
        load_ops(1, -1);
        chk("err_cleared", err_o, 0);
        for (int i = 0; i < 5; i++) push(17'((i + 1) * 11));
        chk("overflow_err", err_o, 1);
        done_i = 1; tick();
        drain(0);

        // Early done after 2 pushes.
        load_ops(1, -1);
        push(17'd11); push(17'd22);
        done_i = 1; tick();
        chk("short_err", err_o, 1);
        exp_out = '{17'd11, 17'd22, 17'd0, 17'd0};
        drain(0);

        // Async reset mid-RUN after one push, with err set by a stray shift during LOAD.
        load_ops(1, 5);
        push(17'd99);
        chk("pre_rst_err", err_o, 1);
        #2 rst = 1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_ld_ready", ld_ready_o, 1);
        chk("arst_err", err_o, 0);
        tick();
        rst = 0;
        load_ops(1, -1);
        run_phase(S, 0);
        rand_drain();

`ifdef FIOS_SERVER_PERF_CNT_EN
        load_ops(0, -1);
        for (int i = 0; i < 37; i++) begin
            if (i < S) begin res_push_i = 1; res_i = 17'(i + 100); exp_out[i] = 17'(i + 100); end
            tick();
        end
        chk("perf_at_done", perf_cnt_o, 32'd37);
        done_i = 1; tick();
        chk("perf_hold", perf_cnt_o, 32'd37);
        drain(2);
        chk("perf_after_out", perf_cnt_o, 32'd37);
`endif

        // Random runs.
        for (int r = 0; r < 20; r++) begin
            if ((r % 4) == 3) begin
                p_fetch_i = 1; tick();
            end
            for (int i = 0; i < 3 * S; i++) ops[i] = 17'($urandom);
            load_ops(1, -1);
            run_phase(S - 1 + int'($urandom % 3), bit'($urandom % 2));
            rand_drain();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
